user_input_checker: RTL and testbench
=====================================

// Module: user_input_checker
// PURPOSE
//  Front end of the player-input path of the Genius game. Debounces the 4 colour buttons,
//  one-hot -> colour encodes each accepted press, fetches the expected colour from sequence
//  memory and compares the two. Emits a 1-cycle hit pulse (drives the E input of the user
//  press counter) or a 1-cycle miss pulse (consumed by the game FSM).
// PARAMETERS
//  N_BTN        4        number of colour buttons (one-hot width); colour code = clog2(N_BTN)
//  ADDR_W       4        sequence-memory address width (max 16 steps)
//  DEB_CYCLES   16       cycles a raw button level must be stable to be accepted (>=2)
//  TIMEOUT_CYC  1000000  idle cycles in WAIT_PRESS before forced miss (TIMEOUT_EN only)
// PORTS
//  clk       in   1       system clock
//  R         in   1       synchronous active-high reset
//  en        in   1       game FSM: player turn active; presses ignored when low
//  clr       in   1       1-cycle pulse at round start; seq_addr <= 0
//  btn       in   N_BTN   raw asynchronous buttons, active-high
//  seq_addr  out  ADDR_W  read address to sequence memory
//  seq_data  in   CW      expected colour code; valid 1 cycle after seq_addr changes
//  hit       out  1       1-cycle pulse: press matched expected colour
//  miss      out  1       1-cycle pulse: wrong colour, multiple buttons, or timeout
//  led       out  N_BTN   echo of the accepted one-hot press while it is held
//  busy      out  1       high in every state except IDLE/WAIT_PRESS
// BEHAVIOUR
//  Reset (R=1 at clk edge): state=IDLE, seq_addr=0, hit=0, miss=0, led=0, busy=0; debouncer cleared.
//  btn passes a 2-flop synchroniser, then the debouncer; btn_db updates after DEB_CYCLES stable cycles.
//  States:
//   IDLE         -> WAIT_PRESS when en=1.
//   WAIT_PRESS   btn_db==0: stay. btn_db!=0 -> latch btn_db into press_r, led<=press_r, -> LOOKUP.
//   LOOKUP       one wait cycle for seq_data (memory read latency 1) -> COMPARE.
//   COMPARE      press_r not one-hot -> miss=1. else enc(press_r)==seq_data -> hit=1,
//                seq_addr<=seq_addr+1; else miss=1. Always -> WAIT_RELEASE.
//   WAIT_RELEASE btn_db==0 -> led<=0, -> WAIT_PRESS (or IDLE if en=0).
//  Latency: debounced press edge -> hit/miss = 2 cycles (LOOKUP, COMPARE; pulse registered out of COMPARE).
//  en=0 in WAIT_PRESS/LOOKUP/COMPARE -> IDLE next cycle, no pulse; in WAIT_RELEASE wait for release first.
//  hit and miss are never high together; each is high exactly 1 cycle per press.
//  seq_addr wraps 2^ADDR_W-1 -> 0 (game FSM guarantees round length <= 2^ADDR_W).
//  clr: seq_addr<=0 in any state; clr coinciding with a hit -> clr wins (addr=0).
//  Held button never re-triggers: a new press needs btn_db to return to 0.
//  R mid-press: all state lost; a button still held after reset is seen as a new press after debounce.
// CONFIGURATION
//  TIMEOUT_EN defined: 20-bit idle counter runs in WAIT_PRESS, cleared on state exit/en low;
//   reaching TIMEOUT_CYC -> miss=1, -> IDLE (game FSM must re-raise en to continue).
//  TIMEOUT_EN undefined: no counter, WAIT_PRESS waits indefinitely; TIMEOUT_CYC unused.
// STRUCTURE
//  genius_pkg: colour code typedef (2 bits), COL_GREEN=0/RED=1/YELLOW=2/BLUE=3,
//   FSM state encoding, one-hot->code encode function.
//  Sub-module btn_debouncer (synchroniser + per-button stable counter, param DEB_CYCLES),
//   one instance of width N_BTN. FSM, compare and address counter in this module.
// TESTING (bench: DEB_CYCLES=4, TIMEOUT_CYC=50, seq memory model with 1-cycle latency)
//  1 mem={2,0,3}, en=1, press btn=4'b0100 for 10 cycles -> hit 1 pulse, seq_addr 0->1, led=0100 while held.
//  2 seq_addr=1 (exp 0), press btn=4'b1000 -> miss 1 pulse, seq_addr stays 1, hit stays 0.
//  3 press btn=4'b0011 together -> miss; hold 40 cycles -> no further pulse; release, press 0001 -> hit.
//  4 btn glitches high 2 cycles -> no hit/miss; R pulse mid-WAIT_RELEASE -> outputs 0, seq_addr=0.
//  5 clr same cycle as a hit -> seq_addr=0 next cycle; seq_addr=15 + hit -> wraps to 0.
//  6 TIMEOUT_EN: en=1, no press 50 cycles -> miss, state IDLE; without macro -> no miss after 200 cycles.

Source files
------------

// File: rtl/genius_pkg.sv
`default_nettype none
// ============================================================================
// Module      : genius_pkg
// Description : Shared colour codes, FSM state encoding and the one-hot to
//               colour-code encoder for the Genius player-input path.
// Revision    : 1.0 - initial release
// ============================================================================
package genius_pkg;

    typedef logic [1:0] colour_t;

    localparam colour_t COL_GREEN  = 2'd0;
    localparam colour_t COL_RED    = 2'd1;
    localparam colour_t COL_YELLOW = 2'd2;
    localparam colour_t COL_BLUE   = 2'd3;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE         = 3'd0;
    localparam logic [ST_W-1:0] ST_WAIT_PRESS   = 3'd1;
    localparam logic [ST_W-1:0] ST_LOOKUP       = 3'd2;
    localparam logic [ST_W-1:0] ST_COMPARE      = 3'd3;
    localparam logic [ST_W-1:0] ST_WAIT_RELEASE = 3'd4;

    // OR of the indices of all set bits; only meaningful for one-hot input
    function automatic colour_t enc_onehot(input logic [3:0] p);
        colour_t c;
        c = '0;
        for (int i = 0; i < 4; i++) begin
            if (p[i]) c = c | colour_t'(i);
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : btn_debouncer
// Description : Two-flop synchroniser followed by a per-button stability
//               counter; an output bit follows its input only after the
//               synchronised level has differed for DEB_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debouncer #(
    parameter int WIDTH      = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             R,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (R) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CNT_W-1:0] r_cnt;
        logic             r_db;

        always_ff @(posedge clk) begin
            if (R) begin
                r_cnt <= '0;
                r_db  <= 1'b0;
            end else if (r_sync2[i] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_db  <= r_sync2[i];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
        end

        assign dout[i] = r_db;
    end

endmodule
`default_nettype wire

// File: rtl/user_input_checker.sv
`default_nettype none
// ============================================================================
// Module      : user_input_checker
// Description : Debounces the colour buttons, compares each accepted press
//               against sequence memory and emits hit/miss pulses.
//               Optional idle timeout enabled by defining TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module user_input_checker
    import genius_pkg::*;
#(
    parameter int N_BTN       = 4,
    parameter int ADDR_W      = 4,
    parameter int DEB_CYCLES  = 16,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     R,
    input  logic                     en,
    input  logic                     clr,
    input  logic [N_BTN-1:0]         btn,
    output logic [ADDR_W-1:0]        seq_addr,
    input  logic [$clog2(N_BTN)-1:0] seq_data,
    output logic                     hit,
    output logic                     miss,
    output logic [N_BTN-1:0]         led,
    output logic                     busy
);

    logic [N_BTN-1:0]  w_db;
    logic              w_onehot;
    logic              w_match;

    logic [ST_W-1:0]   r_state;
    logic [N_BTN-1:0]  r_press;
    logic [ADDR_W-1:0] r_addr;
    logic              r_hit;
    logic              r_miss;
    logic [N_BTN-1:0]  r_led;

`ifdef TIMEOUT_EN
    localparam logic [19:0] C_IDLE_LAST = 20'(TIMEOUT_CYC - 1);
    logic [19:0] r_idle;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |32'(TIMEOUT_CYC);
`endif

    btn_debouncer #(
        .WIDTH      (N_BTN),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk  (clk),
        .R    (R),
        .din  (btn),
        .dout (w_db)
    );

    assign w_onehot = $onehot(r_press);
    assign w_match  = (enc_onehot(r_press) == seq_data);

    always_ff @(posedge clk) begin
        if (R) begin
            r_state <= ST_IDLE;
            r_press <= '0;
            r_addr  <= '0;
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
            r_led   <= '0;
`ifdef TIMEOUT_EN
            r_idle  <= '0;
`endif
        end else begin
            r_hit  <= 1'b0;
            r_miss <= 1'b0;
`ifdef TIMEOUT_EN
            r_idle <= '0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (en) r_state <= ST_WAIT_PRESS;
                end
                ST_WAIT_PRESS: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                    end else if (w_db != '0) begin
                        r_press <= w_db;
                        r_led   <= w_db;
                        r_state <= ST_LOOKUP;
                    end
`ifdef TIMEOUT_EN
                    else if (r_idle == C_IDLE_LAST) begin
                        r_miss  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idle <= r_idle + 20'd1;
                    end
`endif
                end
                ST_LOOKUP: begin
                    if (!en) begin
                        r_led   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (!en) begin
                        r_led   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        if (w_onehot && w_match) begin
                            r_hit  <= 1'b1;
                            r_addr <= r_addr + 1'b1;
                        end else begin
                            r_miss <= 1'b1;
                        end
                        r_state <= ST_WAIT_RELEASE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (w_db == '0) begin
                        r_led   <= '0;
                        r_state <= en ? ST_WAIT_PRESS : ST_IDLE;
                    end
                end
                default: begin
                    r_led   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
            // Round restart overrides any address advance in the same cycle
            if (clr) r_addr <= '0;
        end
    end

    assign seq_addr = r_addr;
    assign hit      = r_hit;
    assign miss     = r_miss;
    assign led      = r_led;
    assign busy     = (r_state == ST_LOOKUP) || (r_state == ST_COMPARE) ||
                      (r_state == ST_WAIT_RELEASE);

endmodule
`default_nettype wire

// File: tb/tb_user_input_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_user_input_checker
// Description : Self-checking bench for user_input_checker with a 1-cycle
//               latency sequence-memory model and a press-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_user_input_checker;

    logic       clk = 1'b0;
    logic       R   = 1'b1;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic [3:0] seq_addr;
    logic [1:0] seq_data;
    logic       hit;
    logic       miss;
    logic [3:0] led;
    logic       busy;

    logic [1:0] mem [16];

    int total_cnt = 0;
    int pass_cnt  = 0;
    int hit_cnt   = 0;
    int miss_cnt  = 0;
    int both_cnt  = 0;

    user_input_checker #(
        .N_BTN       (4),
        .ADDR_W      (4),
        .DEB_CYCLES  (4),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk      (clk),
        .R        (R),
        .en       (en),
        .clr      (clr),
        .btn      (btn),
        .seq_addr (seq_addr),
        .seq_data (seq_data),
        .hit      (hit),
        .miss     (miss),
        .led      (led),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) seq_data <= mem[seq_addr];

    always @(negedge clk) begin
        if (hit)         hit_cnt++;
        if (miss)        miss_cnt++;
        if (hit && miss) both_cnt++;
    end

    // Reference: a press is a hit only if exactly one button is down and
    // its index equals the expected colour code
    function automatic bit ref_is_hit(input logic [3:0] b, input logic [1:0] expc);
        int n;
        int idx;
        n = 0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                n++;
                idx = i;
            end
        end
        return (n == 1) && (idx == int'(expc));
    endfunction

    task automatic press_release(input logic [3:0] b, input int hold,
                                 output logic [3:0] led_seen,
                                 output int nh, output int nm);
        int h0;
        int m0;
        h0 = hit_cnt;
        m0 = miss_cnt;
        btn = b;
        repeat (hold) @(negedge clk);
        led_seen = led;
        btn = 4'b0000;
        repeat (14) @(negedge clk);
        nh = hit_cnt - h0;
        nm = miss_cnt - m0;
    endtask

    task automatic test_reset;
        R = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt += 5;
        if (hit !== 1'b0)         $display("FAIL reset_hit: got %b want 0", hit);   else pass_cnt++;
        if (miss !== 1'b0)        $display("FAIL reset_miss: got %b want 0", miss); else pass_cnt++;
        if (led !== 4'b0000)      $display("FAIL reset_led: got %b want 0000", led); else pass_cnt++;
        if (busy !== 1'b0)        $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        if (seq_addr !== 4'd0)    $display("FAIL reset_addr: got %0d want 0", seq_addr); else pass_cnt++;
        R = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_hit;
        logic [3:0] ls;
        int nh, nm;
        press_release(4'b0100, 12, ls, nh, nm);
        total_cnt += 5;
        if (nh !== 1)          $display("FAIL hit_count: got %0d want 1", nh);  else pass_cnt++;
        if (nm !== 0)          $display("FAIL hit_miss: got %0d want 0", nm);   else pass_cnt++;
        if (ls !== 4'b0100)    $display("FAIL hit_led: got %b want 0100", ls);  else pass_cnt++;
        if (led !== 4'b0000)   $display("FAIL hit_led_release: got %b want 0000", led); else pass_cnt++;
        if (seq_addr !== 4'd1) $display("FAIL hit_addr: got %0d want 1", seq_addr); else pass_cnt++;
    endtask

    task automatic test_miss;
        logic [3:0] ls;
        int nh, nm;
        press_release(4'b1000, 12, ls, nh, nm);
        total_cnt += 3;
        if (nm !== 1)          $display("FAIL miss_count: got %0d want 1", nm); else pass_cnt++;
        if (nh !== 0)          $display("FAIL miss_hit: got %0d want 0", nh);   else pass_cnt++;
        if (seq_addr !== 4'd1) $display("FAIL miss_addr: got %0d want 1", seq_addr); else pass_cnt++;
    endtask

    task automatic test_multi_button;
        logic [3:0] ls;
        int nh, nm;
        press_release(4'b0011, 40, ls, nh, nm);
        total_cnt += 3;
        if (nm !== 1)          $display("FAIL multi_miss: got %0d want 1", nm); else pass_cnt++;
        if (nh !== 0)          $display("FAIL multi_hit: got %0d want 0", nh);  else pass_cnt++;
        if (ls !== 4'b0011)    $display("FAIL multi_led: got %b want 0011", ls); else pass_cnt++;
        press_release(4'b0001, 12, ls, nh, nm);
        total_cnt += 2;
        if (nh !== 1)          $display("FAIL multi_next_hit: got %0d want 1", nh); else pass_cnt++;
        if (seq_addr !== 4'd2) $display("FAIL multi_next_addr: got %0d want 2", seq_addr); else pass_cnt++;
    endtask

    task automatic test_glitch_and_reset;
        int h0, m0;
        h0 = hit_cnt;
        m0 = miss_cnt;
        btn = 4'b1000;
        repeat (2) @(negedge clk);
        btn = 4'b0000;
        repeat (15) @(negedge clk);
        total_cnt += 1;
        if ((hit_cnt - h0) + (miss_cnt - m0) !== 0)
            $display("FAIL glitch_pulses: got %0d want 0", (hit_cnt - h0) + (miss_cnt - m0));
        else pass_cnt++;

        // Accepted press (mem[2]=3), then reset while still held
        h0 = hit_cnt;
        btn = 4'b1000;
        repeat (12) @(negedge clk);
        total_cnt += 2;
        if (hit_cnt - h0 !== 1) $display("FAIL pre_reset_hit: got %0d want 1", hit_cnt - h0); else pass_cnt++;
        if (led !== 4'b1000)    $display("FAIL pre_reset_led: got %b want 1000", led); else pass_cnt++;
        R = 1'b1;
        @(negedge clk);
        total_cnt += 4;
        if (led !== 4'b0000)    $display("FAIL midreset_led: got %b want 0000", led); else pass_cnt++;
        if (busy !== 1'b0)      $display("FAIL midreset_busy: got %b want 0", busy); else pass_cnt++;
        if (seq_addr !== 4'd0)  $display("FAIL midreset_addr: got %0d want 0", seq_addr); else pass_cnt++;
        if (hit !== 1'b0 || miss !== 1'b0)
            $display("FAIL midreset_pulse: got hit=%b miss=%b want 0 0", hit, miss);
        else pass_cnt++;
        R = 1'b0;
        // Still-held button is a fresh press at addr 0 (expects colour 2)
        m0 = miss_cnt;
        repeat (12) @(negedge clk);
        total_cnt += 1;
        if (led !== 4'b1000)    $display("FAIL post_reset_led: got %b want 1000", led); else pass_cnt++;
        btn = 4'b0000;
        repeat (14) @(negedge clk);
        total_cnt += 1;
        if (miss_cnt - m0 !== 1) $display("FAIL post_reset_miss: got %0d want 1", miss_cnt - m0); else pass_cnt++;
    endtask

    task automatic test_clr_with_hit;
        logic [3:0] ls;
        int nh, nm;
        int waited;
        press_release(4'b0100, 12, ls, nh, nm);
        total_cnt += 1;
        if (seq_addr !== 4'd1) $display("FAIL clr_pre_addr: got %0d want 1", seq_addr); else pass_cnt++;
        btn = 4'b0001;
        waited = 0;
        while (busy !== 1'b1 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        total_cnt += 1;
        if (waited >= 30) $display("FAIL clr_wait_busy: got timeout want busy"); else pass_cnt++;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        total_cnt += 2;
        if (hit !== 1'b1)      $display("FAIL clr_hit_pulse: got %b want 1", hit); else pass_cnt++;
        if (seq_addr !== 4'd0) $display("FAIL clr_hit_addr: got %0d want 0", seq_addr); else pass_cnt++;
        btn = 4'b0000;
        repeat (14) @(negedge clk);
    endtask

    task automatic test_wrap;
        logic [3:0] ls;
        int nh, nm;
        int hits;
        for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        total_cnt += 1;
        if (seq_addr !== 4'd0) $display("FAIL wrap_clr_addr: got %0d want 0", seq_addr); else pass_cnt++;
        hits = 0;
        for (int i = 0; i < 16; i++) begin
            press_release(4'b0001 << mem[i], 12, ls, nh, nm);
            hits += nh;
            if (i == 14) begin
                total_cnt += 1;
                if (seq_addr !== 4'd15) $display("FAIL wrap_addr15: got %0d want 15", seq_addr); else pass_cnt++;
            end
        end
        total_cnt += 2;
        if (hits !== 16)       $display("FAIL wrap_hits: got %0d want 16", hits); else pass_cnt++;
        if (seq_addr !== 4'd0) $display("FAIL wrap_addr0: got %0d want 0", seq_addr); else pass_cnt++;
    endtask

    task automatic test_random;
        logic [3:0] ls;
        logic [3:0] b;
        int nh, nm;
        int exp_addr;
        bit exp_hit;
        exp_addr = int'(seq_addr);
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 2) == 0) b = 4'($urandom_range(1, 15));
            else                            b = 4'b0001 << mem[exp_addr];
            exp_hit = ref_is_hit(b, mem[exp_addr]);
            press_release(b, 12, ls, nh, nm);
            if (exp_hit) exp_addr = (exp_addr + 1) % 16;
            total_cnt += 3;
            if (nh !== int'(exp_hit))
                $display("FAIL rand_hit[%0d] btn=%b: got %0d want %0d", k, b, nh, int'(exp_hit));
            else pass_cnt++;
            if (nm !== int'(!exp_hit))
                $display("FAIL rand_miss[%0d] btn=%b: got %0d want %0d", k, b, nm, int'(!exp_hit));
            else pass_cnt++;
            if (int'(seq_addr) !== exp_addr)
                $display("FAIL rand_addr[%0d]: got %0d want %0d", k, seq_addr, exp_addr);
            else pass_cnt++;
        end
    endtask

    task automatic test_timeout;
        int m0;
        en = 1'b0;
        repeat (3) @(negedge clk);
        m0 = miss_cnt;
        en = 1'b1;
`ifdef TIMEOUT_EN
        begin
            int cyc;
            cyc = 0;
            while (miss !== 1'b1 && cyc < 60) begin
                @(negedge clk);
                cyc++;
            end
            en = 1'b0;
            total_cnt += 3;
            if (cyc < 48 || cyc > 54) $display("FAIL timeout_latency: got %0d want 48..54", cyc); else pass_cnt++;
            if (miss_cnt - m0 !== 1)  $display("FAIL timeout_miss: got %0d want 1", miss_cnt - m0); else pass_cnt++;
            if (busy !== 1'b0)        $display("FAIL timeout_busy: got %b want 0", busy); else pass_cnt++;
        end
`else
        repeat (200) @(negedge clk);
        total_cnt += 1;
        if (miss_cnt - m0 !== 0) $display("FAIL no_timeout_miss: got %0d want 0", miss_cnt - m0); else pass_cnt++;
`endif
        en = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 2'd0;
        mem[0] = 2'd2;
        mem[1] = 2'd0;
        mem[2] = 2'd3;
        test_reset();
        test_hit();
        test_miss();
        test_multi_button();
        test_glitch_and_reset();
        test_clr_with_hit();
        test_wrap();
        test_random();
        test_timeout();
        total_cnt += 1;
        if (both_cnt !== 0) $display("FAIL hit_and_miss_together: got %0d want 0", both_cnt); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
